// File: rtl/decode_stage_p.sv
// decode_stage_p: WISC instruction decode stage.
//   Decodes the IF/ID instruction and reads an internal register file. The
//   register file has an optional write-through bypass. Branches are resolved
//   in ID and a misprediction produces a registered redirect pulse. Load-use
//   and flag hazards stall the stage. Results go to an ID/EX register that
//   uses a valid/ready handshake.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   in_valid/in_ready, inst,        IF/ID handshake, instruction word,
//   pc_next, pred_taken             fall-through PC and fetch prediction
//   flags                           {Z,V,N} from the flag register
//   ex_flag_wr/ex_mem_read/ex_rd    hazard info for the instruction in EX
//   wb_en/wb_rd/wb_data             register-file write port
//   flush                           kill ID instruction and ID/EX contents
//   out_valid/out_ready, out_*      ID/EX register and handshake
//   redirect/redirect_pc            misprediction pulse and correct fetch PC
module decode_stage_p #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 16,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       inst,
  input  logic [DATA_W-1:0] pc_next,
  input  logic              pred_taken,
  input  logic [2:0]        flags,
  input  logic              ex_flag_wr,
  input  logic              ex_mem_read,
  input  logic [3:0]        ex_rd,
  input  logic              wb_en,
  input  logic [3:0]        wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        out_opcode,
  output logic [3:0]        out_rd,
  output logic [DATA_W-1:0] out_src1,
  output logic [DATA_W-1:0] out_src2,
  output logic [DATA_W-1:0] out_imm,
  output logic [7:0]        out_ctrl,
  output logic              redirect,
  output logic [DATA_W-1:0] redirect_pc
);

  localparam int RI_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  // Branch condition on {Z,V,N}; 3'b111 is unconditional.
  function automatic logic cond_met(input logic [2:0] c, input logic z,
                                    input logic v, input logic n);
    case (c)
      3'b000:  return !z;
      3'b001:  return z;
      3'b010:  return !z && !n;
      3'b011:  return n;
      3'b100:  return z || (!z && !n);
      3'b101:  return n || z;
      3'b110:  return v;
      default: return 1'b1;
    endcase
  endfunction

  // Immediate extension from the low instruction byte.
  function automatic logic [DATA_W-1:0] imm_ext(input logic [3:0] op,
                                                input logic [7:0] f);
    logic signed [DATA_W-1:0] s;
    s = '0;
    case (op)
      4'h8, 4'h9:       s = {{(DATA_W-4){f[3]}}, f[3:0]};
      4'h4, 4'h5, 4'h6: s = {{(DATA_W-4){1'b0}}, f[3:0]};
      4'hA, 4'hB:       s = {{(DATA_W-8){1'b0}}, f};
      default:          s = '0;
    endcase
    return s;
  endfunction

  // Register file
  logic [DATA_W-1:0] rf_q [NUM_REGS];
  logic [DATA_W-1:0] rf_d [NUM_REGS];

  logic [3:0]      opcode;
  logic [2:0]      cond;
  logic [RI_W-1:0] rd_idx, rs_idx, rt_idx, wb_idx, ex_idx;
  logic [DATA_W-1:0] rd_data, rs_data, rt_data;

  assign opcode = inst[15:12];
  assign cond   = inst[11:9];
  assign rd_idx = inst[8 +: RI_W];
  assign rs_idx = inst[4 +: RI_W];
  assign rt_idx = inst[0 +: RI_W];
  assign wb_idx = wb_rd[RI_W-1:0];
  assign ex_idx = ex_rd[RI_W-1:0];

  always_comb begin
    rf_d = rf_q;
    if (wb_en && (wb_idx != '0)) rf_d[wb_idx] = wb_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
    end else begin
      rf_q <= rf_d;
    end
  end

  // Reads: R0 is hard zero; optional same-cycle write-through.
  always_comb begin
    rd_data = '0;
    rs_data = '0;
    rt_data = '0;
    if (rd_idx != '0)
      rd_data = ((BYPASS != 0) && wb_en && (wb_idx == rd_idx)) ? wb_data : rf_q[rd_idx];
    if (rs_idx != '0)
      rs_data = ((BYPASS != 0) && wb_en && (wb_idx == rs_idx)) ? wb_data : rf_q[rs_idx];
    if (rt_idx != '0)
      rt_data = ((BYPASS != 0) && wb_en && (wb_idx == rt_idx)) ? wb_data : rf_q[rt_idx];
  end

  // Control decode
  logic reg_write, mem_en, mem_wr, mem_to_reg, alu_src, z_en, nv_en, hlt;
  logic use_rs, use_rt, use_rd, is_br;

  always_comb begin
    reg_write  = (opcode <= 4'h8) || (opcode == 4'hA) || (opcode == 4'hB) ||
                 (opcode == 4'hE);
    mem_en     = (opcode == 4'h8) || (opcode == 4'h9);
    mem_wr     = (opcode == 4'h9);
    mem_to_reg = (opcode == 4'h8);
    alu_src    = ((opcode >= 4'h4) && (opcode <= 4'h6)) ||
                 ((opcode >= 4'h8) && (opcode <= 4'hB));
    z_en       = (opcode <= 4'h6);
    nv_en      = (opcode <= 4'h1);
    hlt        = (opcode == 4'hF);
    use_rs     = (opcode <= 4'h9) || (opcode == 4'hD);
    use_rt     = (opcode <= 4'h7);
    use_rd     = (opcode >= 4'h9) && (opcode <= 4'hB);
    is_br      = (opcode == 4'hC) || (opcode == 4'hD);
  end

  // Hazards and handshake
  logic load_use, flag_haz, stall, advance, accept;

  assign load_use = ex_mem_read && (ex_idx != '0) &&
                    ((use_rs && (ex_idx == rs_idx)) ||
                     (use_rt && (ex_idx == rt_idx)) ||
                     (use_rd && (ex_idx == rd_idx)));
  assign flag_haz = is_br && (cond != 3'b111) && ex_flag_wr;
  assign stall    = in_valid && (load_use || flag_haz);
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance && !stall && !flush;
  assign accept   = in_valid && in_ready;

  // Branch resolution
  logic signed [DATA_W-1:0] br_off;
  logic [DATA_W-1:0] br_target;
  logic taken;

  assign br_off    = {{(DATA_W-10){inst[8]}}, inst[8:0], 1'b0};
  assign br_target = (opcode == 4'hD) ? rs_data : (pc_next + br_off);
  assign taken     = cond_met(cond, flags[2], flags[1], flags[0]);

  // ID/EX register and redirect
  logic              out_valid_q, out_valid_d;
  logic [3:0]        out_opcode_q, out_opcode_d, out_rd_q, out_rd_d;
  logic [DATA_W-1:0] out_src1_q, out_src1_d, out_src2_q, out_src2_d;
  logic [DATA_W-1:0] out_imm_q, out_imm_d;
  logic [7:0]        out_ctrl_q, out_ctrl_d;
  logic              redirect_q, redirect_d;
  logic [DATA_W-1:0] redirect_pc_q, redirect_pc_d;

  always_comb begin
    out_valid_d   = out_valid_q;
    out_opcode_d  = out_opcode_q;
    out_rd_d      = out_rd_q;
    out_src1_d    = out_src1_q;
    out_src2_d    = out_src2_q;
    out_imm_d     = out_imm_q;
    out_ctrl_d    = out_ctrl_q;
    redirect_d    = 1'b0;
    redirect_pc_d = redirect_pc_q;

    if (flush) begin
      out_valid_d = 1'b0;
    end else if (advance) begin
      // A stall or empty IF/ID loads a bubble; data fields keep old contents.
      out_valid_d = accept;
    end

    if (accept) begin
      out_opcode_d = opcode;
      out_rd_d     = inst[11:8];
      out_src1_d   = ((opcode == 4'hA) || (opcode == 4'hB)) ? rd_data : rs_data;
      out_src2_d   = (opcode == 4'h9) ? rd_data : rt_data;
      out_imm_d    = imm_ext(opcode, inst[7:0]);
      out_ctrl_d   = {reg_write, mem_en, mem_wr, mem_to_reg, alu_src, z_en, nv_en, hlt};
      if (is_br && (taken != pred_taken)) begin
        redirect_d    = 1'b1;
        redirect_pc_d = taken ? br_target : pc_next;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q   <= 1'b0;
      out_opcode_q  <= '0;
      out_rd_q      <= '0;
      out_src1_q    <= '0;
      out_src2_q    <= '0;
      out_imm_q     <= '0;
      out_ctrl_q    <= '0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      out_valid_q   <= out_valid_d;
      out_opcode_q  <= out_opcode_d;
      out_rd_q      <= out_rd_d;
      out_src1_q    <= out_src1_d;
      out_src2_q    <= out_src2_d;
      out_imm_q     <= out_imm_d;
      out_ctrl_q    <= out_ctrl_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_opcode  = out_opcode_q;
  assign out_rd      = out_rd_q;
  assign out_src1    = out_src1_q;
  assign out_src2    = out_src2_q;
  assign out_imm     = out_imm_q;
  assign out_ctrl    = out_ctrl_q;
  assign redirect    = redirect_q;
  assign redirect_pc = redirect_pc_q;

endmodule

// File: tb/tb_decode_stage_p.sv
// Testbench for decode_stage_p: scoreboard queues plus a negedge monitor.
module tb_decode_stage_p;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, in_valid, pred_taken, ex_flag_wr, ex_mem_read, wb_en, flush, out_ready;
  logic [15:0] inst, pc_next, wb_data;
  logic [2:0]  flags;
  logic [3:0]  ex_rd, wb_rd;

  logic        in_ready, out_valid, redirect;
  logic [3:0]  out_opcode, out_rd;
  logic [15:0] out_src1, out_src2, out_imm, redirect_pc;
  logic [7:0]  out_ctrl;

  logic        nb_in_ready, nb_out_valid, nb_redirect;
  logic [3:0]  nb_out_opcode, nb_out_rd;
  logic [15:0] nb_out_src1, nb_out_src2, nb_out_imm, nb_redirect_pc;
  logic [7:0]  nb_out_ctrl;

  decode_stage_p #(.DATA_W(16), .NUM_REGS(16), .BYPASS(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .inst(inst),
    .pc_next(pc_next), .pred_taken(pred_taken), .flags(flags), .ex_flag_wr(ex_flag_wr),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .wb_en(wb_en), .wb_rd(wb_rd),
    .wb_data(wb_data), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_rd(out_rd), .out_src1(out_src1), .out_src2(out_src2),
    .out_imm(out_imm), .out_ctrl(out_ctrl), .redirect(redirect), .redirect_pc(redirect_pc)
  );

  decode_stage_p #(.DATA_W(16), .NUM_REGS(16), .BYPASS(0)) u_nobyp (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(nb_in_ready), .inst(inst),
    .pc_next(pc_next), .pred_taken(pred_taken), .flags(flags), .ex_flag_wr(ex_flag_wr),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .wb_en(wb_en), .wb_rd(wb_rd),
    .wb_data(wb_data), .flush(flush), .out_valid(nb_out_valid), .out_ready(out_ready),
    .out_opcode(nb_out_opcode), .out_rd(nb_out_rd), .out_src1(nb_out_src1),
    .out_src2(nb_out_src2), .out_imm(nb_out_imm), .out_ctrl(nb_out_ctrl),
    .redirect(nb_redirect), .redirect_pc(nb_redirect_pc)
  );

  typedef struct packed {
    logic [3:0]  op;
    logic [3:0]  rd;
    logic [15:0] s1;
    logic [15:0] s2;
    logic [15:0] imm;
    logic [7:0]  ctrl;
  } exp_t;

  exp_t        q_out[$];
  logic [15:0] q_red[$];
  exp_t        mon_e;
  logic [15:0] mon_pc;
  int          n_cmp = 0;
  int          n_bad = 0;

  function automatic exp_t mk(input logic [3:0] op, input logic [3:0] rd,
                              input logic [15:0] s1, input logic [15:0] s2,
                              input logic [15:0] imm, input logic [7:0] ctrl);
    exp_t e;
    e.op = op; e.rd = rd; e.s1 = s1; e.s2 = s2; e.imm = imm; e.ctrl = ctrl;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one instruction, require acceptance, record expected response.
  task automatic issue(input logic [15:0] i, input logic pt, input exp_t e,
                       input logic has_red, input logic [15:0] rpc);
    in_valid = 1'b1; inst = i; pred_taken = pt;
    #1;
    chk("in_ready_accept", in_ready, 1);
    q_out.push_back(e);
    if (has_red) q_red.push_back(rpc);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Monitor: compare whatever the DUT presents against the queues.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (q_out.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_out: got opcode 0x%0h, expected no output", out_opcode);
        end else begin
          mon_e = q_out.pop_front();
          chk("out_opcode", out_opcode, mon_e.op);
          chk("out_rd",     out_rd,     mon_e.rd);
          chk("out_src1",   out_src1,   mon_e.s1);
          chk("out_src2",   out_src2,   mon_e.s2);
          chk("out_imm",    out_imm,    mon_e.imm);
          chk("out_ctrl",   out_ctrl,   mon_e.ctrl);
        end
      end
      if (redirect) begin
        if (q_red.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_redirect: got redirect_pc 0x%0h, expected no redirect", redirect_pc);
        end else begin
          mon_pc = q_red.pop_front();
          chk("redirect_pc", redirect_pc, mon_pc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; inst = '0; pc_next = '0; pred_taken = 1'b0;
    flags = '0; ex_flag_wr = 1'b0; ex_mem_read = 1'b0; ex_rd = '0; wb_en = 1'b0;
    wb_rd = '0; wb_data = '0; flush = 1'b0; out_ready = 1'b0;
    step(); step();

    // reset state
    chk("rst_out_valid", out_valid, 0);
    chk("rst_redirect", redirect, 0);
    chk("rst_out_ctrl", out_ctrl, 0);
    chk("rst_out_src1", out_src1, 0);
    chk("rst_redirect_pc", redirect_pc, 0);
    rst_n = 1'b1;
    out_ready = 1'b1;

    // register file cleared by reset
    issue(16'h0534, 1'b0, mk(4'h0, 4'h5, 16'h0000, 16'h0000, 16'h0000, 8'h86), 1'b0, 16'h0);

    // WB writes then ADD R5,R3,R4
    wb_en = 1'b1; wb_rd = 4'd3; wb_data = 16'h1234; step();
    wb_rd = 4'd4; wb_data = 16'h0001; step();
    wb_en = 1'b0;
    issue(16'h0534, 1'b0, mk(4'h0, 4'h5, 16'h1234, 16'h0001, 16'h0000, 8'h86), 1'b0, 16'h0);

    // same-cycle write of R3 while ID reads it
    wb_en = 1'b1; wb_rd = 4'd3; wb_data = 16'hBEEF;
    issue(16'h0534, 1'b0, mk(4'h0, 4'h5, 16'hBEEF, 16'h0001, 16'h0000, 8'h86), 1'b0, 16'h0);
    wb_en = 1'b0;
    chk("nobypass_valid", nb_out_valid, 1);
    chk("nobypass_src1", nb_out_src1, 16'h1234);

    // load-use stall on SW R3,R2,4
    ex_mem_read = 1'b1; ex_rd = 4'd3;
    in_valid = 1'b1; inst = 16'h9324;
    #1;
    chk("loaduse_in_ready", in_ready, 0);
    step();
    chk("loaduse_bubble", out_valid, 0);
    ex_mem_read = 1'b0;
    issue(16'h9324, 1'b0, mk(4'h9, 4'h3, 16'h0000, 16'hBEEF, 16'h0004, 8'h68), 1'b0, 16'h0);

    // B EQ taken, mispredicted then correctly predicted
    pc_next = 16'h0010; flags = 3'b100;
    issue(16'hC3FE, 1'b0, mk(4'hC, 4'h3, 16'h0, 16'h0, 16'h0, 8'h00), 1'b1, 16'h000C);
    issue(16'hC3FE, 1'b1, mk(4'hC, 4'h3, 16'h0, 16'h0, 16'h0, 8'h00), 1'b0, 16'h0);
    step();

    // flag hazard stalls a conditional branch
    ex_flag_wr = 1'b1;
    in_valid = 1'b1; inst = 16'hC3FE; pred_taken = 1'b0;
    #1;
    chk("flagstall_in_ready", in_ready, 0);
    step();
    chk("flagstall_bubble", out_valid, 0);
    chk("flagstall_redirect", redirect, 0);
    // unconditional branch ignores the flag hazard
    pc_next = 16'h0100;
    issue(16'hCFFE, 1'b0, mk(4'hC, 4'hF, 16'h0, 16'h0, 16'h0, 8'h00), 1'b1, 16'h00FC);
    ex_flag_wr = 1'b0;

    // mixed instruction stream
    pc_next = 16'h0020; flags = 3'b000;
    issue(16'hA6A5, 1'b0, mk(4'hA, 4'h6, 16'h0000, 16'h0000, 16'h00A5, 8'h88), 1'b0, 16'h0);
    issue(16'h873F, 1'b0, mk(4'h8, 4'h7, 16'hBEEF, 16'h0000, 16'hFFFF, 8'hD8), 1'b0, 16'h0);
    issue(16'h4135, 1'b0, mk(4'h4, 4'h1, 16'hBEEF, 16'h0000, 16'h0005, 8'h8C), 1'b0, 16'h0);
    issue(16'hDE40, 1'b0, mk(4'hD, 4'hE, 16'h0001, 16'h0000, 16'h0000, 8'h00), 1'b1, 16'h0001);
    issue(16'hF000, 1'b0, mk(4'hF, 4'h0, 16'h0000, 16'h0000, 16'h0000, 8'h01), 1'b0, 16'h0);
    issue(16'hE000, 1'b0, mk(4'hE, 4'h0, 16'h0000, 16'h0000, 16'h0000, 8'h80), 1'b0, 16'h0);
    issue(16'h1234, 1'b0, mk(4'h1, 4'h2, 16'hBEEF, 16'h0001, 16'h0000, 8'h86), 1'b0, 16'h0);
    issue(16'h7234, 1'b0, mk(4'h7, 4'h2, 16'hBEEF, 16'h0001, 16'h0000, 8'h80), 1'b0, 16'h0);

    // backpressure hold, then flush
    in_valid = 1'b1; inst = 16'h0534;
    #1;
    chk("bp_accept", in_ready, 1);
    step();
    out_ready = 1'b0; inst = 16'h4135;
    #1;
    chk("bp_in_ready", in_ready, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("hold_valid", out_valid, 1);
      chk("hold_src1", out_src1, 16'hBEEF);
      chk("hold_src2", out_src2, 16'h0001);
      chk("hold_ctrl", out_ctrl, 8'h86);
      chk("hold_in_ready", in_ready, 0);
    end
    flush = 1'b1; inst = 16'hC3FE; pred_taken = 1'b0; flags = 3'b100; pc_next = 16'h0010;
    #1;
    chk("flush_in_ready", in_ready, 0);
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_valid", out_valid, 0);
    chk("flush_redirect", redirect, 0);
    step();
    chk("flush_redirect_late", redirect, 0);

    // asynchronous reset mid-run
    out_ready = 1'b1;
    in_valid = 1'b1; inst = 16'h0534;
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    chk("pre_reset_valid", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_src1", out_src1, 0);
    chk("async_rst_ctrl", out_ctrl, 0);
    chk("async_rst_rd", out_rd, 0);
    chk("async_rst_redirect_pc", redirect_pc, 0);
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (3) step();

    chk("q_out_drained", q_out.size(), 0);
    chk("q_red_drained", q_red.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/decode_stage_p.md
Name: decode_stage_p

Overview:
- Parametrised successor decode stage for the WISC pipeline.
- Decodes the IF/ID instruction, reads an internal NUM_REGS x DATA_W register file with write-through bypass, and resolves branches in ID with misprediction redirect.
- Detects load-use and flag hazards and stalls accordingly.
- Drives a registered ID/EX output with a valid/ready handshake, so backpressure from EX is honoured without losing instructions.

Parameters:
DATA_W, 16, datapath width (>=16); immediates are extended to DATA_W
NUM_REGS, 16, register count (power of 2, <=16); register index = low log2(NUM_REGS) bits of each instruction field
BYPASS, 1, 1 = same-cycle WB write visible to ID reads; 0 = read returns old value

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  IF/ID holds a valid instruction
in_ready  out  1  ID accepts the instruction this cycle
inst  in  16  instruction word
pc_next  in  DATA_W  address of the following instruction
pred_taken  in  1  fetch-stage prediction for inst
flags  in  3  {Z,V,N} from the flag register
ex_flag_wr  in  1  instruction now in EX writes Z or NV flags
ex_mem_read  in  1  instruction now in EX is LW
ex_rd  in  4  destination register of the EX instruction
wb_en  in  1  register-file write enable
wb_rd  in  4  write register
wb_data  in  DATA_W  write data
flush  in  1  kill the ID instruction and the output register contents
out_valid  out  1  ID/EX register holds a valid instruction
out_ready  in  1  EX consumes the ID/EX register this cycle
out_opcode  out  4  opcode
out_rd  out  4  destination register
out_src1  out  DATA_W  Rs data (Rd data for LLB/LHB)
out_src2  out  DATA_W  Rt data (Rd data for SW)
out_imm  out  DATA_W  extended immediate
out_ctrl  out  8  {RegWrite, MemEnable, MemWrite, MemToReg, ALUSrc, Z_en, NV_en, HLT}
redirect  out  1  one-cycle misprediction pulse
redirect_pc  out  DATA_W  correct fetch address

Behaviour:
- Reset (async, rst_n=0):
  - All out_* = 0; out_valid = 0; redirect = 0.
  - Register file cleared to 0.
- Opcode map:
  - 0-7 ALU ops (ADD, SUB, XOR, RED, SLL, SRA, ROR, PADDSB).
  - 8 LW, 9 SW, A LLB, B LHB, C B, D BR, E PCS, F HLT.
- Control decode:
  - RegWrite for 0-8, A, B, E.
  - Z_en for 0-6; NV_en for 0-1.
  - ALUSrc for 4-6 and 8-B.
- Immediates:
  - LW/SW: sign-extended inst[3:0].
  - Shifts (4-6): zero-extended inst[3:0].
  - LLB/LHB: zero-extended inst[7:0].
  - All others: 0.
- Register file:
  - Register 0 always reads 0; writes to register 0 are ignored.
  - With BYPASS=1, when wb_en and wb_rd matches a source register, ID reads wb_data in the same cycle.
- Source use:
  - Rs is used by 0-9 and D.
  - Rt is used by 0-7.
  - Rd is used as a source by 9-B.
- Load-use stall: ex_mem_read & ex_rd!=0 & ex_rd equals any used source register.
- Flag stall: opcode C/D & cond!=3'b111 & ex_flag_wr.
- On a stall:
  - in_ready = 0.
  - A bubble (out_valid=0) is loaded into ID/EX if ID/EX advances.
  - Branch is not resolved; redirect stays 0.
- Advance rule:
  - ID/EX advances when !out_valid | out_ready.
  - in_ready = advance & !stall.
- Hold under backpressure: when out_valid & !out_ready, every out_* field is held stable.
- Branch resolution (only when in_valid & in_ready):
  - cond = inst[11:9].
  - Conditions: 000 Z=0; 001 Z=1; 010 Z=0&N=0; 011 N=1; 100 Z=1|(Z=0&N=0); 101 N=1|Z=1; 110 V=1; 111 always.
  - B target = pc_next + (sext(inst[8:0])<<1), mod 2^DATA_W.
  - BR target = Rs data.
  - Mispredict when taken != pred_taken.
  - redirect_pc = target if taken, else pc_next.
- Redirect timing:
  - redirect is registered: it asserts the cycle after acceptance, for exactly 1 cycle.
  - redirect_pc is held until the next redirect.
- Latency: an accepted instruction appears on out_* the next cycle.
- Branches enter ID/EX with RegWrite=0 (PCS is the exception: RegWrite=1).
- Flush:
  - Synchronous.
  - Next cycle out_valid = 0; any pending redirect is suppressed.
  - in_ready is forced to 0 that cycle.
  - flush has priority over stall and accept.
- HLT passes through with the HLT ctrl bit set; the block does not stop itself.

Test Plan:
- Reset then WB writes R3=0x1234, R4=0x0001; ADD R5,R3,R4 with out_ready=1 -> next cycle out_valid=1, out_src1=0x1234, out_src2=0x0001, out_ctrl RegWrite=1, Z_en=1, NV_en=1.
- BYPASS=1: same cycle wb_en writes R3=0xBEEF while ID reads R3 -> out_src1=0xBEEF. With BYPASS=0, the same stimulus gives the old value.
- ex_mem_read=1, ex_rd=3, inst SW R3,R2,4 -> in_ready=0 and one bubble. Deasserting ex_mem_read -> accepted, out_imm=0x0004.
- B cond=001 (EQ), imm=0x1FE, pc_next=0x0010, flags Z=1, pred_taken=0 -> redirect pulses 1 cycle with redirect_pc=0x000C. Repeating with pred_taken=1 -> no redirect.
- ex_flag_wr=1 with a conditional B -> stalled and no redirect. With cond=111 -> no stall.
- out_ready=0 for 3 cycles -> out_* held, in_ready=0. Then flush=1 -> out_valid=0 and no redirect. Mid-test rst_n=0 -> outputs clear immediately, without waiting for a clock edge.
